fp_div_arbiter: RTL and testbench

- Shares one fp_division_pipeline instance between NUM_REQ requesters, each using a valid/ready handshake.
- Round-robin arbitration, at most one issue per cycle into the divider.
- Tracks the requester ID of every in-flight operation and buffers completed results in a FIFO with a valid/ready consumer port.
- Credit-based admission guarantees results never overflow the FIFO; the divider itself cannot stall.

---
 rtl/fp_div_arbiter_pkg.sv | 37 +++
 rtl/fp_div_arbiter_sync_fifo.sv | 67 ++++++
 rtl/fp_div_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_fp_div_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_arbiter_pkg
// Description : Shared types and constants for the divider arbiter: flag
//               layout, rounding-mode encoding and the buffered response
//               record.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_div_arbiter_pkg;

    // Divider flag vector is {overflow, underflow, inexact, invalid, div0}
    localparam int ARB_FLAGS_W       = 5;
    localparam int FLAG_DIV_BY_ZERO  = 0;
    localparam int FLAG_INVALID_OP   = 1;
    localparam int FLAG_INEXACT      = 2;
    localparam int FLAG_UNDERFLOW    = 3;
    localparam int FLAG_OVERFLOW     = 4;

    // Widest requester ID the arbiter supports (NUM_REQ up to 8)
    localparam int MAX_ID_W = 3;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rounding_mode_t;

    typedef struct packed {
        logic [MAX_ID_W-1:0]    id;
        logic [31:0]            result;
        logic [ARB_FLAGS_W-1:0] flags;
    } fp_div_resp_t;

endpackage
`default_nettype wire

// File: rtl/fp_div_arbiter_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_arbiter_sync_fifo
// Description : Synchronous FIFO with register-array storage, head output
//               forced to zero while empty, and an occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_div_arbiter_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign valid    = (count != '0);
    assign do_pop   = pop & valid;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = valid ? mem[rd_ptr] : '0;

    // Storage write; contents need no reset because the head is gated by valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_arbiter
// Description : Round-robin front end sharing one non-stallable FP divider
//               between NUM_REQ requesters. Credits (in-flight + buffered)
//               bound admission so the result FIFO can never overflow.
//               Optional macro FP_DIV_ARB_PERF_EN adds issue and credit-stall
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_div_arbiter
    import fp_div_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int RESULT_DEPTH = 8,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_in1,
    input  logic [NUM_REQ*32-1:0]  req_in2,
    input  logic [NUM_REQ*3-1:0]   req_rounding_mode,
    output logic                   div_valid_data_in,
    output logic [31:0]            div_in1,
    output logic [31:0]            div_in2,
    output logic [2:0]             div_rounding_mode,
    input  logic [31:0]            div_out,
    input  logic [ARB_FLAGS_W-1:0] div_flags,
    input  logic                   div_valid_data_out,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [31:0]            resp_out,
    output logic [ARB_FLAGS_W-1:0] resp_flags,
    output logic                   busy,
    output logic                   err_unexpected
`ifdef FP_DIV_ARB_PERF_EN
    ,
    output logic [31:0]            perf_issued,
    output logic [31:0]            perf_credit_stalls
`endif
);

    localparam int CNT_W = $clog2(RESULT_DEPTH + 1);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  idx;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic             credit_ok;
    logic             handshake;
    logic [31:0]      sel_in1;
    logic [31:0]      sel_in2;
    rounding_mode_t   sel_rm;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] result_count;
    logic [CNT_W:0]   occ;
    logic [ID_W-1:0]  tag_head;
    logic             tag_valid;
    logic             result_push;
    fp_div_resp_t     resp_push;
    fp_div_resp_t     resp_head;

    // Every accepted op holds a credit until its result leaves the FIFO
    assign occ       = {1'b0, inflight} + {1'b0, result_count};
    assign credit_ok = (occ < (CNT_W + 1)'(RESULT_DEPTH));
    assign handshake = found & credit_ok;
    assign req_ready = handshake ? (NUM_REQ'(1) << winner) : '0;
    assign busy      = (occ != '0) | div_valid_data_in;

    // Round-robin search from rr_ptr, then mux the winner's operands
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        idx     = rr_ptr;
        sel_in1 = '0;
        sel_in2 = '0;
        sel_rm  = RM_RNE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner == ID_W'(j)) begin
                sel_in1 = req_in1[j*32 +: 32];
                sel_in2 = req_in2[j*32 +: 32];
                sel_rm  = rounding_mode_t'(req_rounding_mode[j*3 +: 3]);
            end
        end
    end

    // Issue register: one-cycle strobe, operands hold between issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr            <= '0;
            div_valid_data_in <= 1'b0;
            div_in1           <= '0;
            div_in2           <= '0;
            div_rounding_mode <= '0;
        end else begin
            div_valid_data_in <= handshake;
            if (handshake) begin
                rr_ptr            <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                div_in1           <= sel_in1;
                div_in2           <= sel_in2;
                div_rounding_mode <= sel_rm;
            end
        end
    end

    // Sticky error for a divider result that has no outstanding tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unexpected <= 1'b0;
        end else if (div_valid_data_out && !tag_valid) begin
            err_unexpected <= 1'b1;
        end
    end

    // Tag FIFO occupancy doubles as the in-flight counter
    fp_div_arbiter_sync_fifo #(
        .WIDTH (ID_W),
        .DEPTH (RESULT_DEPTH),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (handshake),
        .push_data (winner),
        .pop       (div_valid_data_out),
        .pop_data  (tag_head),
        .valid     (tag_valid),
        .count     (inflight)
    );

    // Pair the completing result with the oldest tag; orphans are dropped
    always_comb begin
        result_push = div_valid_data_out & tag_valid;
        resp_push   = '{id: MAX_ID_W'(tag_head), result: div_out, flags: div_flags};
    end

    fp_div_arbiter_sync_fifo #(
        .WIDTH ($bits(fp_div_resp_t)),
        .DEPTH (RESULT_DEPTH),
        .CNT_W (CNT_W)
    ) u_result_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (result_push),
        .push_data (resp_push),
        .pop       (resp_ready),
        .pop_data  (resp_head),
        .valid     (resp_valid),
        .count     (result_count)
    );

    assign resp_id    = ID_W'(resp_head.id);
    assign resp_out   = resp_head.result;
    assign resp_flags = resp_head.flags;

`ifdef FP_DIV_ARB_PERF_EN
    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued        <= '0;
            perf_credit_stalls <= '0;
        end else begin
            if (handshake) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (|req_valid && !credit_ok) begin
                perf_credit_stalls <= perf_credit_stalls + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_div_arbiter
// Description : Self-checking bench for fp_div_arbiter with a 16-cycle
//               divider stub and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_div_arbiter;
    import fp_div_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 8;
    localparam int ID_W    = 2;
    localparam int LAT     = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_in1;
    logic [NUM_REQ*32-1:0] req_in2;
    logic [NUM_REQ*3-1:0]  req_rounding_mode;
    logic                  div_valid_data_in;
    logic [31:0]           div_in1;
    logic [31:0]           div_in2;
    logic [2:0]            div_rounding_mode;
    logic [31:0]           div_out;
    logic [4:0]            div_flags;
    logic                  div_valid_data_out;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_out;
    logic [4:0]            resp_flags;
    logic                  busy;
    logic                  err_unexpected;

    fp_div_arbiter #(.NUM_REQ(NUM_REQ), .RESULT_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_in1            (req_in1),
        .req_in2            (req_in2),
        .req_rounding_mode  (req_rounding_mode),
        .div_valid_data_in  (div_valid_data_in),
        .div_in1            (div_in1),
        .div_in2            (div_in2),
        .div_rounding_mode  (div_rounding_mode),
        .div_out            (div_out),
        .div_flags          (div_flags),
        .div_valid_data_out (div_valid_data_out),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_id            (resp_id),
        .resp_out           (resp_out),
        .resp_flags         (resp_flags),
        .busy               (busy),
        .err_unexpected     (err_unexpected)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: known IEEE cases exact, others a distinctive mix
    function automatic logic [36:0] div_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C00000 && b == 32'h40000000) return {5'b00000, 32'h40400000};
        if (a[30:0] == '0 && b[30:0] == '0)        return {5'b00010, 32'h7FC00000};
        if (b[30:0] == '0)                          return {5'b00001, a[31] ^ b[31], 31'h7F800000};
        return {5'b00100, a ^ {b[15:0], b[31:16]}};
    endfunction

    logic [LAT-1:0] pv;
    logic [31:0]    pa [LAT];
    logic [31:0]    pb [LAT];
    logic           inject = 1'b0;
    logic [36:0]    stub_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], div_valid_data_in};
            pa[0] <= div_in1;
            pb[0] <= div_in2;
            for (int i = 1; i < LAT; i++) begin
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
            end
        end
    end

    assign stub_res           = div_model(pa[LAT-1], pb[LAT-1]);
    assign div_out            = stub_res[31:0];
    assign div_flags          = stub_res[36:32];
    assign div_valid_data_out = pv[LAT-1] | inject;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and handshake monitor, sampled on the falling edge
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     res;
        logic [4:0]      fl;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    int          grant_log [$];
    int          hs_cyc_log [$];
    int          hs_count = 0;
    int          pop_count = 0;
    int          last_hs_cyc = 0;
    int          last_pop_cyc = 0;
    logic [38:0] last_resp = '0;
    logic [36:0] mon_m;

    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_onehot", {127'd0, ($onehot0(req_ready) && ((req_ready & ~req_valid) == '0))}, 128'd1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_m = div_model(req_in1[i*32 +: 32], req_in2[i*32 +: 32]);
                    sb.push_back({ID_W'(i), mon_m[31:0], mon_m[36:32]});
                    grant_log.push_back(i);
                    hs_cyc_log.push_back(cyc);
                    hs_count++;
                    last_hs_cyc = cyc;
                end
            end
            if (resp_valid && resp_ready) begin
                check("resp_expected", {127'd0, sb.size() != 0}, 128'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("resp_data", {resp_id, resp_out, resp_flags}, e);
                end
                last_resp    = {resp_id, resp_out, resp_flags};
                last_pop_cyc = cyc;
                pop_count++;
            end
        end
    end

    task automatic set_ops(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        req_in1[idx*32 +: 32]          = a;
        req_in2[idx*32 +: 32]          = b;
        req_rounding_mode[idx*3 +: 3]  = rm;
    endtask

    task automatic issue_one(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        set_ops(idx, a, b, rm);
        req_valid[idx] = 1'b1;
        while (!got && n < 50) begin
            @(negedge clk);
            got = req_ready[idx];
            n++;
        end
        check("issue_grant", {127'd0, got}, 128'd1);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int bound);
        int n;
        n = 0;
        while (hs_count < target && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        check("hs_reached", {127'd0, hs_count >= target}, 128'd1);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || resp_valid) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", {125'd0, sb.size() == 0, busy, resp_valid}, 128'b100);
    endtask

    initial begin
        int base;
        int pbase;
        int hs;
        int n;

        req_valid         = '0;
        req_in1           = '0;
        req_in2           = '0;
        req_rounding_mode = '0;
        resp_ready        = 1'b0;
        rst_n             = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_ready", req_ready, 0);
        check("rst_issue", {div_valid_data_in, div_in1, div_in2, div_rounding_mode}, 0);
        check("rst_resp", {resp_valid, resp_id, resp_out, resp_flags}, 0);
        check("rst_status", {busy, err_unexpected}, 0);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;

        // Four requesters competing continuously
        for (int i = 0; i < NUM_REQ; i++)
            set_ops(i, 32'h3F800000 + i, 32'h40000000 + (i << 20), 3'(RM_RNE));
        base = hs_count;
        grant_log.delete();
        hs_cyc_log.delete();
        req_valid = '1;
        wait_hs(base + 16, 400);
        req_valid = '0;
        check("rr_grants", grant_log.size(), 16);
        for (int k = 0; k < grant_log.size(); k++)
            check("rr_order", grant_log[k], k % NUM_REQ);
        for (int k = 1; k < 8 && k < hs_cyc_log.size(); k++)
            check("rr_back_to_back", hs_cyc_log[k] - hs_cyc_log[k-1], 1);
        drain(300);

        // Single op from requester 0, latency and value
        issue_one(0, 32'h40C00000, 32'h40000000, 3'(RM_RNE));
        hs = last_hs_cyc;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 60);
        check("latency", cyc - hs, 18);
        check("single_result", {resp_id, resp_out, resp_flags}, {2'd0, 32'h40400000, 5'd0});
        drain(100);

        // Division by zero and 0/0 from requester 2
        issue_one(2, 32'h3F800000, 32'h00000000, 3'(RM_RNE));
        drain(100);
        check("div_by_zero", last_resp, {2'd2, 32'h7F800000, 5'b00001});
        issue_one(2, 32'h00000000, 32'h00000000, 3'(RM_RTZ));
        drain(100);
        check("zero_by_zero", last_resp, {2'd2, 32'h7FC00000, 5'b00010});

        // Back-pressure: credits cap acceptance at DEPTH
        resp_ready = 1'b0;
        base  = hs_count;
        pbase = pop_count;
        for (int i = 0; i < NUM_REQ; i++)
            set_ops(i, 32'h41000000 + (i << 4), 32'h3F000000 + i, 3'(RM_RUP));
        req_valid = '1;
        repeat (40) @(posedge clk);
        #1;
        check("bp_accepted", hs_count - base, 8);
        @(negedge clk);
        check("bp_ready_low", req_ready, 0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bp_one_more", hs_count - base, 9);
        check("bp_issue_after_pop", last_hs_cyc - last_pop_cyc, 1);
        req_valid  = '0;
        resp_ready = 1'b1;
        drain(300);
        check("bp_no_loss", pop_count - pbase, 9);

        // Reset with five operations in flight
        for (int i = 0; i < NUM_REQ; i++)
            set_ops(i, 32'h42000000 + i, 32'h40400000 + (i << 8), 3'(RM_RNE));
        base = hs_count;
        req_valid = '1;
        wait_hs(base + 5, 100);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_issue", {div_valid_data_in, div_in1, div_in2, div_rounding_mode}, 0);
        check("mid_rst_resp", {resp_valid, resp_id, resp_out, resp_flags}, 0);
        check("mid_rst_status", {busy, err_unexpected}, 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue_one(1, 32'h40C00000, 32'h40000000, 3'(RM_RNE));
        drain(100);
        check("post_rst_result", last_resp, {2'd1, 32'h40400000, 5'd0});
        check("post_rst_err", err_unexpected, 0);

        // Orphan divider result
        pbase = pop_count;
        @(posedge clk); #1;
        inject = 1'b1;
        @(posedge clk); #1;
        inject = 1'b0;
        check("orphan_err", err_unexpected, 1);
        check("orphan_no_resp", resp_valid, 0);
        repeat (5) @(posedge clk);
        #1;
        check("orphan_err_sticky", err_unexpected, 1);
        check("orphan_idle", {resp_valid, busy}, 0);
        check("orphan_no_pop", pop_count - pbase, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
